// File: rtl/pc_ctrl.sv
// Program counter and run control: IDLE/RUN/DONE sequencing, beq resolution, retired-instruction count.
// Next state is registered one edge after the inputs are sampled; stall freezes RUN for exactly one cycle per cycle held.
module pc_ctrl #(
  parameter int         PC_W   = 10,
  parameter int         CNT_W  = 16,
  parameter logic [2:0] BEQ_OP = 3'b001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic [2:0]       alu_op,
  input  logic             branch_en,
  input  logic             alu_zero,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             halt,
  output logic [PC_W-1:0]  pc,
  output logic             done,
  output logic             branch_taken,
  output logic             pc_ovf,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic             done_nxt;
  logic             branch_taken_nxt;
  logic             pc_ovf_nxt;
  logic [CNT_W-1:0] instr_count_nxt;

  logic             taken;
  logic             pc_at_max;
  logic [CNT_W-1:0] count_sat_inc;

  // Only beq is a conditional branch; branch_en with any other opcode falls through.
  assign taken         = branch_en && (alu_op == BEQ_OP) && alu_zero;
  assign pc_at_max     = &pc;
  assign count_sat_inc = (&instr_count) ? instr_count : instr_count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= '0;
      done         <= 1'b0;
      branch_taken <= 1'b0;
      pc_ovf       <= 1'b0;
      instr_count  <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      done         <= done_nxt;
      branch_taken <= branch_taken_nxt;
      pc_ovf       <= pc_ovf_nxt;
      instr_count  <= instr_count_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    done_nxt         = done;
    branch_taken_nxt = branch_taken;
    pc_ovf_nxt       = pc_ovf;
    instr_count_nxt  = instr_count;

    if (start) begin
      state_nxt        = IDLE;
      pc_nxt           = '0;
      done_nxt         = 1'b0;
      branch_taken_nxt = 1'b0;
      pc_ovf_nxt       = 1'b0;
      instr_count_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          // Entry edge only arms RUN; the PC 0 instruction retires on the next edge.
          state_nxt        = RUN;
          pc_nxt           = '0;
          branch_taken_nxt = 1'b0;
        end
        RUN: begin
          if (stall) begin
            branch_taken_nxt = 1'b0;
          end else if (halt) begin
            state_nxt        = DONE;
            done_nxt         = 1'b1;
            branch_taken_nxt = 1'b0;
            instr_count_nxt  = count_sat_inc;
          end else if (taken) begin
            pc_nxt           = branch_target;
            branch_taken_nxt = 1'b1;
            instr_count_nxt  = count_sat_inc;
          end else begin
            pc_nxt           = pc + 1'b1;
            branch_taken_nxt = 1'b0;
            instr_count_nxt  = count_sat_inc;
            if (pc_at_max) begin
              pc_ovf_nxt = 1'b1;
            end
          end
        end
        DONE: begin
          // Halted: everything holds until start or reset.
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Randomized and directed bench for pc_ctrl against a behavioural program-counter model.
module tb_pc_ctrl;

  localparam int PC_W    = 10;
  localparam int CNT_W   = 6;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic [2:0]       alu_op = 3'd0;
  logic             branch_en = 1'b0;
  logic             alu_zero = 1'b0;
  logic [PC_W-1:0]  branch_target = '0;
  logic             halt = 1'b0;
  logic [PC_W-1:0]  pc;
  logic             done;
  logic             branch_taken;
  logic             pc_ovf;
  logic [CNT_W-1:0] instr_count;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit running, halted;
  int m_pc, m_cnt;
  bit m_done, m_bt, m_ovf;

  pc_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .BEQ_OP(3'b001)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .alu_op(alu_op),
    .branch_en(branch_en), .alu_zero(alu_zero), .branch_target(branch_target),
    .halt(halt), .pc(pc), .done(done), .branch_taken(branch_taken),
    .pc_ovf(pc_ovf), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void retire();
    if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
  endfunction

  function automatic void model_edge();
    if (reset || start) begin
      running = 0; halted = 0;
      m_pc = 0; m_done = 0; m_bt = 0; m_ovf = 0; m_cnt = 0;
    end else if (!running && !halted) begin
      running = 1;
    end else if (running) begin
      if (stall) begin
        m_bt = 0;
      end else if (halt) begin
        running = 0; halted = 1; m_done = 1; m_bt = 0;
        retire();
      end else if (branch_en && alu_op == 3'b001 && alu_zero) begin
        m_pc = int'(branch_target); m_bt = 1;
        retire();
      end else begin
        if (m_pc == PC_MOD - 1) m_ovf = 1;
        m_pc = (m_pc + 1) % PC_MOD; m_bt = 0;
        retire();
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pc", 32'(pc), 32'(m_pc));
    check("done", 32'(done), 32'(m_done));
    check("branch_taken", 32'(branch_taken), 32'(m_bt));
    check("pc_ovf", 32'(pc_ovf), 32'(m_ovf));
    check("instr_count", 32'(instr_count), 32'(m_cnt));
  endtask

  task automatic drive(input bit rs, input bit st, input bit sl, input bit [2:0] op,
                       input bit be, input bit z, input int tgt, input bit h);
    reset = rs; start = st; stall = sl; alu_op = op;
    branch_en = be; alu_zero = z; branch_target = PC_W'(tgt); halt = h;
    step();
  endtask

  task automatic plain();
    drive(0, 0, 0, 3'd0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset and start sequence: pc 0,0,1,2,3,4
    drive(1, 0, 0, 3'd0, 0, 0, 0, 0);
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_cnt", 32'(instr_count), 32'd0);
    repeat (3) drive(0, 1, 0, 3'd0, 0, 0, 0, 0);
    check("start_pc", 32'(pc), 32'd0);
    repeat (5) plain();
    check("seq_pc", 32'(pc), 32'd4);
    check("seq_cnt", 32'(instr_count), 32'd4);
    check("seq_done", 32'(done), 32'd0);
    plain();
    drive(0, 0, 0, 3'b001, 1, 1, 32'h020, 0);
    check("beq_taken_pc", 32'(pc), 32'h020);
    check("beq_taken_flag", 32'(branch_taken), 32'd1);
    plain();
    check("beq_flag_clears", 32'(branch_taken), 32'd0);
    drive(0, 0, 0, 3'b001, 1, 1, 5, 0);
    drive(0, 0, 0, 3'b001, 1, 0, 32'h020, 0);
    check("beq_not_equal_pc", 32'(pc), 32'd6);
    check("beq_not_equal_flag", 32'(branch_taken), 32'd0);
    drive(0, 0, 0, 3'b010, 1, 1, 32'h020, 0);
    check("wrong_op_pc", 32'(pc), 32'd7);
    repeat (3) begin
      drive(0, 0, 1, 3'd0, 0, 0, 0, 0);
      check("stall_pc", 32'(pc), 32'd7);
    end
    plain();
    check("resume_pc", 32'(pc), 32'd8);
    plain();
    drive(0, 0, 0, 3'b001, 1, 1, 32'h100, 1);
    check("halt_done", 32'(done), 32'd1);
    check("halt_pc", 32'(pc), 32'd9);
    drive(0, 0, 1, 3'd0, 0, 0, 0, 0);
    plain();
    check("done_hold_pc", 32'(pc), 32'd9);
    drive(0, 1, 0, 3'd0, 0, 0, 0, 0);
    check("restart_done", 32'(done), 32'd0);
    check("restart_cnt", 32'(instr_count), 32'd0);
    plain();
    plain();
    drive(0, 0, 0, 3'b001, 1, 1, PC_MOD - 1, 0);
    check("branch_to_max_ovf", 32'(pc_ovf), 32'd0);
    plain();
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_ovf", 32'(pc_ovf), 32'd1);
    repeat (3) plain();
    check("ovf_sticky", 32'(pc_ovf), 32'd1);
    drive(1, 0, 1, 3'd0, 0, 0, 0, 0);
    check("midrun_reset_pc", 32'(pc), 32'd0);
    check("midrun_reset_ovf", 32'(pc_ovf), 32'd0);
    // Counter saturation
    plain();
    repeat (CNT_MAX + 10) plain();
    check("cnt_saturates", 32'(instr_count), 32'(CNT_MAX));

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(99) == 0),
            ($urandom_range(29) == 0),
            ($urandom_range(4) == 0),
            ($urandom_range(1) == 0) ? 3'b001 : 3'($urandom_range(7)),
            ($urandom_range(2) == 0),
            1'($urandom_range(1)),
            ($urandom_range(3) == 0) ? PC_MOD - 1 : int'($urandom_range(PC_MOD - 1)),
            ($urandom_range(39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
